// File: rtl/arcade_input_conditioner_if.sv
// Button bus between the raw cabinet inputs and the game core.
// master: input source (board / bench); slave: the conditioner.
interface arcade_input_conditioner_if;
  logic [7:0] btn_in;      // raw active-high buttons, asynchronous to the core clock
  logic [7:0] BUTTON;      // conditioned active-low buttons
  logic       coin_event;  // one-cycle strobe per accepted coin

  modport master (
    output btn_in,
    input  BUTTON,
    input  coin_event
  );

  modport slave (
    input  btn_in,
    output BUTTON,
    output coin_event
  );
endinterface

// File: rtl/arcade_input_conditioner.sv
// Arcade button conditioner: per-bit 2-flop synchronizer, per-bit debounce,
// registered active-low outputs, and a coin shaper that turns each accepted
// coin press into one fixed-width low pulse followed by a hold-off.
module arcade_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned COIN_PULSE      = 1250000,
  parameter int unsigned COIN_GAP        = 2500000
) (
  input logic                        clk_25,
  input logic                        reset,
  arcade_input_conditioner_if.slave  bus
);

  localparam int unsigned DbW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CoinMax = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int unsigned CoinW   = $clog2(CoinMax + 1);

  localparam logic [DbW-1:0]   DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CoinW-1:0] PulseLast = CoinW'(COIN_PULSE - 1);
  localparam logic [CoinW-1:0] GapLast   = CoinW'(COIN_GAP - 1);

  typedef enum logic [1:0] {StIdle, StPulse, StHoldoff, StWaitRel} coin_st_e;

  logic [7:0]     s1_q, s2_q;
  logic [7:0]     stable_q, stable_d;
  logic [DbW-1:0] db_cnt_q [8];
  logic [DbW-1:0] db_cnt_d [8];

  coin_st_e         coin_st_q, coin_st_d;
  logic [CoinW-1:0] coin_cnt_q, coin_cnt_d;
  logic             coin_prev_q;
  logic             coin_rise;

  logic [7:0] button_q, button_d;
  logic       coin_event_q, coin_event_d;

  // Two-flop synchronizer on every raw input bit
  always_ff @(posedge clk_25) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.btn_in;
      s2_q <= s1_q;
    end
  end

  // Debounce next state: count consecutive cycles the synced bit disagrees with stable
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 8; i++) begin
      db_cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          stable_d[i] = s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk_25) begin
    if (reset) begin
      stable_q <= '0;
      for (int i = 0; i < 8; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < 8; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign coin_rise = stable_q[2] & ~coin_prev_q;

  // Coin FSM state register
  always_ff @(posedge clk_25) begin
    if (reset) begin
      coin_st_q   <= StIdle;
      coin_cnt_q  <= '0;
      coin_prev_q <= 1'b0;
    end else begin
      coin_st_q   <= coin_st_d;
      coin_cnt_q  <= coin_cnt_d;
      coin_prev_q <= stable_q[2];
    end
  end

  // Coin FSM next state; presses outside StIdle are dropped, never queued
  always_comb begin
    coin_st_d  = coin_st_q;
    coin_cnt_d = coin_cnt_q;
    case (coin_st_q)
      StIdle: begin
        if (coin_rise) begin
          coin_st_d  = StPulse;
          coin_cnt_d = '0;
        end
      end
      StPulse: begin
        if (coin_cnt_q == PulseLast) begin
          coin_st_d  = StHoldoff;
          coin_cnt_d = '0;
        end else begin
          coin_cnt_d = coin_cnt_q + CoinW'(1);
        end
      end
      StHoldoff: begin
        if (coin_cnt_q == GapLast) begin
          coin_st_d  = StWaitRel;
          coin_cnt_d = '0;
        end else begin
          coin_cnt_d = coin_cnt_q + CoinW'(1);
        end
      end
      StWaitRel: begin
        if (!stable_q[2]) begin
          coin_st_d = StIdle;
        end
      end
      default: begin
        coin_st_d  = StIdle;
        coin_cnt_d = '0;
      end
    endcase
  end

  // Output decode; coin bit follows the next FSM state so it lines up with the other bits
  always_comb begin
    button_d     = ~stable_q;
    button_d[2]  = (coin_st_d != StPulse);
    coin_event_d = (coin_st_q == StIdle) && coin_rise;
  end

  // Output register keeps BUTTON and coin_event glitch-free
  always_ff @(posedge clk_25) begin
    if (reset) begin
      button_q     <= 8'hFF;
      coin_event_q <= 1'b0;
    end else begin
      button_q     <= button_d;
      coin_event_q <= coin_event_d;
    end
  end

  assign bus.BUTTON     = button_q;
  assign bus.coin_event = coin_event_q;

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Self-checking bench: directed scenarios plus random button traffic, all
// compared cycle by cycle against a behavioural model of the conditioner.
module tb_arcade_input_conditioner;

  localparam int DB = 4;
  localparam int CP = 8;
  localparam int CG = 6;

  logic       clk;
  logic [7:0] btn_v;
  logic       rst_v;

  arcade_input_conditioner_if bus ();
  assign bus.btn_in = btn_v;

  arcade_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .COIN_PULSE     (CP),
    .COIN_GAP       (CG)
  ) dut (
    .clk_25(clk),
    .reset (rst_v),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ev_cnt   = 0;
  int low_cnt  = 0;

  // Model state: input delay line, debounce window, accepted levels, coin timeline
  logic [7:0] m_sync [$];
  logic [7:0] m_win  [$];
  logic [7:0] m_stable, m_stable_prev;
  int         low_left, gap_left;
  bit         wait_rel;
  logic [7:0] exp_button;
  logic       exp_coin;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // A level is accepted once the synced input has shown the opposite value
  // for DB consecutive cycles; the coin is a timeline of low / gap / release.
  task automatic model_step(input logic [7:0] btn, input logic rst);
    logic [7:0] din, nst;
    bit         all_flip;
    if (rst) begin
      m_sync.delete();
      m_sync.push_back(8'h00);
      m_sync.push_back(8'h00);
      m_win.delete();
      for (int k = 0; k < DB; k++) m_win.push_back(8'h00);
      m_stable      = '0;
      m_stable_prev = '0;
      low_left      = 0;
      gap_left      = 0;
      wait_rel      = 1'b0;
      exp_button    = 8'hFF;
      exp_coin      = 1'b0;
    end else begin
      exp_coin = 1'b0;
      if (low_left == 0 && gap_left == 0 && !wait_rel) begin
        if (m_stable[2] && !m_stable_prev[2]) begin
          exp_coin = 1'b1;
          low_left = CP;
        end
      end else if (low_left > 0) begin
        low_left--;
        if (low_left == 0) gap_left = CG;
      end else if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) wait_rel = 1'b1;
      end else if (!m_stable[2]) begin
        wait_rel = 1'b0;
      end
      exp_button    = ~m_stable;
      exp_button[2] = (low_left == 0);

      din = m_sync.pop_front();
      m_sync.push_back(btn);
      void'(m_win.pop_front());
      m_win.push_back(din);
      nst = m_stable;
      for (int b = 0; b < 8; b++) begin
        all_flip = 1'b1;
        for (int k = 0; k < DB; k++) begin
          if (m_win[k][b] == m_stable[b]) all_flip = 1'b0;
        end
        if (all_flip) nst[b] = ~m_stable[b];
      end
      m_stable_prev = m_stable;
      m_stable      = nst;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(btn_v, rst_v);
    #1;
    check_eq("button", {24'h0, bus.BUTTON}, {24'h0, exp_button});
    check_eq("coin_event", {31'h0, bus.coin_event}, {31'h0, exp_coin});
    ev_cnt += int'(bus.coin_event);
    if (!bus.BUTTON[2]) low_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int hold;
  bit found;

  initial begin
    btn_v = 8'hFF;
    rst_v = 1'b1;

    // Reset with all buttons pressed
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_button", {24'h0, bus.BUTTON}, 32'hFF);
      check_eq("rst_coin", {31'h0, bus.coin_event}, 32'h0);
    end
    btn_v = 8'h00;
    rst_v = 1'b0;
    run(10);

    // Short fire pulse is rejected
    btn_v = 8'h08;
    run(3);
    btn_v = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("short_pulse", {24'h0, bus.BUTTON}, 32'hFF);
    end

    // Fire held: falls at edge 6, release rises 6 edges later
    btn_v = 8'h08;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 5) check_eq("fire_before", {31'h0, bus.BUTTON[3]}, 32'h1);
      if (e == 6) check_eq("fire_press", {31'h0, bus.BUTTON[3]}, 32'h0);
    end
    run(5);
    btn_v = 8'h00;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 5) check_eq("fire_rel_before", {31'h0, bus.BUTTON[3]}, 32'h0);
      if (e == 6) check_eq("fire_release", {31'h0, bus.BUTTON[3]}, 32'h1);
    end
    run(5);

    // Held coin gives one credit and one 8-cycle pulse; re-press gives another
    ev_cnt = 0; low_cnt = 0;
    btn_v = 8'h04;
    run(40);
    btn_v = 8'h00;
    run(20);
    check_eq("held_coin_events", ev_cnt, 1);
    check_eq("held_coin_low", low_cnt, CP);
    btn_v = 8'h04;
    run(30);
    btn_v = 8'h00;
    run(20);
    check_eq("repress_events", ev_cnt, 2);
    check_eq("repress_low", low_cnt, 2 * CP);

    // Second press lands in hold-off and is dropped
    ev_cnt = 0; low_cnt = 0;
    btn_v = 8'h04; run(6);
    btn_v = 8'h00; run(6);
    btn_v = 8'h04; run(10);
    btn_v = 8'h00; run(30);
    check_eq("holdoff_events", ev_cnt, 1);
    check_eq("holdoff_low", low_cnt, CP);

    // Reset in the middle of a pulse aborts it
    btn_v = 8'h04;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      found = bus.coin_event;
    end
    check_eq("coin_wait", {31'h0, found}, 32'h1);
    run(2);
    rst_v = 1'b1;
    btn_v = 8'h00;
    tick();
    check_eq("abort_button2", {31'h0, bus.BUTTON[2]}, 32'h1);
    check_eq("abort_all", {24'h0, bus.BUTTON}, 32'hFF);
    rst_v = 1'b0;
    run(10);
    ev_cnt = 0; low_cnt = 0;
    btn_v = 8'h04; run(40);
    btn_v = 8'h00; run(20);
    check_eq("after_abort_events", ev_cnt, 1);
    check_eq("after_abort_low", low_cnt, CP);

    // Coin held through reset release is re-debounced into one credit
    btn_v = 8'h04;
    rst_v = 1'b1; run(2);
    ev_cnt = 0; low_cnt = 0;
    rst_v = 1'b0; run(40);
    btn_v = 8'h00; run(20);
    check_eq("held_rst_events", ev_cnt, 1);
    check_eq("held_rst_low", low_cnt, CP);

    // Left and right together fall on the same edge
    btn_v = 8'hC0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 5) check_eq("lr_before", {30'h0, bus.BUTTON[7:6]}, 32'h3);
      if (e == 6) check_eq("lr_press", {30'h0, bus.BUTTON[7:6]}, 32'h0);
    end
    btn_v = 8'h00;
    run(10);

    // Random bouncing traffic with occasional resets
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        btn_v ^= 8'(1 << $urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) btn_v ^= 8'($urandom);
        hold = $urandom_range(1, 10);
      end
      hold--;
      rst_v = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
